normalize_shift_pipe: RTL and testbench
=======================================

// Module: normalize_shift_pipe
// PURPOSE
//  Post-addition normalizer for the multi-precision posit FMA datapath; the counterpart
//  of exponent alignment. Alignment right-shifts the smaller addend and derives swap and
//  shift from exponent differences. This block runs after the adder: it finds the
//  leading one of each sum lane, left-shifts it to the lane MSB and subtracts the shift
//  from the lane exponent. Two-stage pipeline with valid/ready on both sides.
// PARAMETERS
//  LANE_MW  16  mantissa bits per quarter lane; MANT_W = 4*LANE_MW
//  LANE_EW  5   exponent bits per quarter lane; EXP_W = 4*LANE_EW (20 by default)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       input beat valid
//  in_ready   out  1       block accepts a beat this cycle
//  in_pre     in   2       00: 4 quarter lanes; 01: 2 half lanes; 10: 1 full lane; 11 = 00
//  in_mant    in   MANT_W  unsigned magnitude of the sum, lanes packed LSB-first
//  in_exp     in   EXP_W   two's-complement lane exponents, packed as in_mant
//  out_valid  out  1       output beat valid
//  out_ready  in   1       downstream accepts the beat
//  out_pre    out  2       in_pre of this beat, 11 normalised to 00
//  out_mant   out  MANT_W  normalized mantissa lanes
//  out_exp    out  EXP_W   adjusted lane exponents
//  out_zero   out  4       per-lane zero flag (quarter-lane indexed, see below)
//  out_uflow  out  4       per-lane exponent underflow flag
// BEHAVIOUR
//  - Lane geometry. pre=00: lane i = mant[16i+15:16i], exp[5i+4:5i], flag bit i.
//    pre=01: lane j = mant[32j+31:32j], exp[10j+9:10j], flag bit 2j+1; bits 0,2 = 0.
//    pre=10: one lane mant[63:0], exp[19:0], flag bit 3; bits 0..2 = 0.
//  - Per lane of width W, for a nonzero mantissa:
//    lzc = leading-zero count (0..W-1). out_mant = mant << lzc, so the lane MSB = 1.
//    out_exp = exp - lzc, computed in lane width+1 and then truncated.
//  - A lane never shifts into, or borrows from, its neighbour.
//  - uflow = 1 when the true signed result exp - lzc is below -2^(lane_ew-1).
//    out_exp then saturates to the most-negative lane value, and mant is still shifted.
//  - Zero lane (mant == 0): out_mant = 0, out_exp = most-negative value, zero = 1,
//    uflow = 0.
//  - Stage S1 registers the inputs, the per-quarter LZC and the per-quarter all-zero bits.
//    Half and full lanes combine these: the upper part's count if it is nonzero,
//    else W/2 + the lower part's count.
//  - Stage S2 registers the shifted mantissa, exponent and flags.
//  - Latency: exactly 2 cycles from the in_valid && in_ready edge to out_valid when the
//    pipe is not stalled.
//  - Handshake. s2_adv = !s2_v | out_ready; s1_adv = !s1_v | s2_adv; in_ready = s1_adv.
//    This is purely combinational from the valid registers and out_ready; no bubble when
//    streaming. out_valid = s2_v.
//  - A beat is transferred when valid && ready. Data is held stable while
//    out_valid && !out_ready.
//  - Full throughput: 1 beat/cycle with out_ready held high. A stalled, full pipe holds
//    2 beats and drops none.
//  - Simultaneous events: S2 drains and S1 refills in the same cycle. in_pre may change
//    every beat, and each beat carries its own pre.
//  - Reset (any time, including mid-stream): s1_v = s2_v = 0, out_valid = 0,
//    out_mant = 0, out_exp = 0, out_pre = 0, out_zero = 0, out_uflow = 0.
//    In-flight beats are discarded. in_ready = 1 from the first cycle after reset
//    deasserts.
// TESTING
//  1. pre=00, mant lanes {0x0001, 0x8000, 0x0F00, 0x0000}, exp lanes {5, 3, 0, 7}, lane0
//     first -> mant {0x8000, 0x8000, 0xF000, 0}, exp {-10, 3, -4, -16},
//     zero = 4'b1000, uflow = 0.
//  2. pre=01, lane0 mant 0x0000_0001, exp 10'sd100 -> mant 0x8000_0000, exp 69;
//     lane1 mant 0 -> zero bit3 = 1, exp = -512.
//  3. pre=10, mant 64'h1, exp -20'sd524270 -> lzc 63, exp saturates to -524288,
//     uflow bit3 = 1, mant = 64'h8000_0000_0000_0000.
//  4. Stream 8 beats with out_ready = 1 -> outputs in order, 1 per cycle, first out_valid
//     2 cycles after the first accept.
//  5. Hold out_ready = 0 for 5 cycles while in_valid = 1 -> exactly 2 beats accepted,
//     in_ready = 0 afterwards, out_* stable. Release -> no loss or duplication.
//  6. Assert rst with 2 beats in flight -> out_valid = 0 and all outputs zero
//     immediately, with no stale beat after release.

Source files
------------

// File: rtl/normalize_shift_pipe.sv
// normalize_shift_pipe: two-stage per-lane leading-one normalizer with valid/ready handshake
module normalize_shift_pipe #(
  parameter int LANE_MW = 16,
  parameter int LANE_EW = 5,
  localparam int MANT_W = 4 * LANE_MW,
  localparam int EXP_W = 4 * LANE_EW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_pre,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_pre,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [3:0]        out_zero,
  output logic [3:0]        out_uflow
);
  localparam int LQ = $clog2(LANE_MW);
  localparam int HW = 2 * LANE_MW;
  localparam int HE = 2 * LANE_EW;
  logic s1_v, s2_v, s1_adv, s2_adv;
  logic [1:0] s1_pre;
  logic [MANT_W-1:0] s1_mant, f_mant, n_mant;
  logic [EXP_W-1:0] s1_exp, f_exp, n_exp;
  logic [3:0][LQ-1:0] s1_lz, in_lz;
  logic [3:0] s1_z, in_z, q_uf, n_zero, n_uflow;
  logic [3:0][LANE_MW-1:0] q_mant;
  logic [3:0][LANE_EW-1:0] q_exp;
  logic [1:0][LQ:0] h_lz;
  logic [1:0][HW-1:0] h_mant;
  logic [1:0][HE-1:0] h_exp;
  logic [1:0] h_z, h_uf;
  logic [LQ+1:0] f_lz;
  logic [EXP_W:0] f_d;
  logic f_z, f_uf;

  function automatic logic [LQ-1:0] lzc(input logic [LANE_MW-1:0] m);
    lzc = '0;
    for (int i = 0; i < LANE_MW; i++) if (m[i]) lzc = LQ'(LANE_MW - 1 - i);
  endfunction

  for (genvar q = 0; q < 4; q++) begin : g_q
    logic [LANE_EW:0] d;
    assign in_lz[q] = lzc(in_mant[q*LANE_MW +: LANE_MW]);
    assign in_z[q] = ~|in_mant[q*LANE_MW +: LANE_MW];
    assign d = {s1_exp[q*LANE_EW+LANE_EW-1], s1_exp[q*LANE_EW +: LANE_EW]} - (LANE_EW+1)'(s1_lz[q]);
    assign q_mant[q] = s1_mant[q*LANE_MW +: LANE_MW] << s1_lz[q];
    assign q_uf[q] = !s1_z[q] && d[LANE_EW] != d[LANE_EW-1];
    assign q_exp[q] = s1_z[q] || q_uf[q] ? {1'b1, {(LANE_EW-1){1'b0}}} : d[LANE_EW-1:0];
  end

  for (genvar h = 0; h < 2; h++) begin : g_h
    logic [HE:0] d;
    assign h_z[h] = s1_z[2*h+1] & s1_z[2*h];
    assign h_lz[h] = s1_z[2*h+1] ? (LQ+1)'(LANE_MW) + (LQ+1)'(s1_lz[2*h]) : (LQ+1)'(s1_lz[2*h+1]);
    assign d = {s1_exp[h*HE+HE-1], s1_exp[h*HE +: HE]} - (HE+1)'(h_lz[h]);
    assign h_mant[h] = s1_mant[h*HW +: HW] << h_lz[h];
    assign h_uf[h] = !h_z[h] && d[HE] != d[HE-1];
    assign h_exp[h] = h_z[h] || h_uf[h] ? {1'b1, {(HE-1){1'b0}}} : d[HE-1:0];
  end

  assign f_z = h_z[1] & h_z[0];
  assign f_lz = h_z[1] ? (LQ+2)'(HW) + (LQ+2)'(h_lz[0]) : (LQ+2)'(h_lz[1]);
  assign f_d = {s1_exp[EXP_W-1], s1_exp} - (EXP_W+1)'(f_lz);
  assign f_mant = s1_mant << f_lz;
  assign f_uf = !f_z && f_d[EXP_W] != f_d[EXP_W-1];
  assign f_exp = f_z || f_uf ? {1'b1, {(EXP_W-1){1'b0}}} : f_d[EXP_W-1:0];

  always_comb begin
    n_mant = s1_pre[1] ? f_mant : s1_pre[0] ? h_mant : q_mant;
    n_exp = s1_pre[1] ? f_exp : s1_pre[0] ? h_exp : q_exp;
    n_zero = s1_pre[1] ? {f_z, 3'b000} : s1_pre[0] ? {h_z[1], 1'b0, h_z[0], 1'b0} : s1_z;
    n_uflow = s1_pre[1] ? {f_uf, 3'b000} : s1_pre[0] ? {h_uf[1], 1'b0, h_uf[0], 1'b0} : q_uf;
  end

  assign s2_adv = !s2_v || out_ready;
  assign s1_adv = !s1_v || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_pre <= '0;
      s1_mant <= '0;
      s1_exp <= '0;
      s1_lz <= '0;
      s1_z <= '0;
      s2_v <= 1'b0;
      out_pre <= '0;
      out_mant <= '0;
      out_exp <= '0;
      out_zero <= '0;
      out_uflow <= '0;
    end else begin
      if (s1_adv) s1_v <= in_valid;
      if (s1_adv && in_valid) begin
        s1_pre <= in_pre == 2'b11 ? 2'b00 : in_pre;
        s1_mant <= in_mant;
        s1_exp <= in_exp;
        s1_lz <= in_lz;
        s1_z <= in_z;
      end
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        out_pre <= s1_pre;
        out_mant <= n_mant;
        out_exp <= n_exp;
        out_zero <= n_zero;
        out_uflow <= n_uflow;
      end
    end
  end
endmodule

// File: tb/tb_normalize_shift_pipe.sv
// tb_normalize_shift_pipe: randomized and directed checks of normalize_shift_pipe against a lane model
module tb_normalize_shift_pipe;
  typedef struct packed {
    logic [1:0] pre;
    logic [63:0] mant;
    logic [19:0] exp;
    logic [3:0] zero;
    logic [3:0] uflow;
  } beat_t;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] in_pre = 0;
  logic [63:0] in_mant = 0;
  logic [19:0] in_exp = 0;
  logic [1:0] out_pre;
  logic [63:0] out_mant;
  logic [19:0] out_exp;
  logic [3:0] out_zero, out_uflow;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  beat_t acc_q[$];
  beat_t got_q[$];
  int acc_c[$];
  int got_c[$];

  normalize_shift_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pre(in_pre),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_pre(out_pre), .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero),
    .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t model(input logic [1:0] pre, input logic [63:0] m, input logic [19:0] e);
    beat_t r;
    int n, w, ew, lz, fb;
    logic [63:0] msk, emsk, lm;
    longint ev, minv, res;
    n = pre == 2'b10 ? 1 : pre == 2'b01 ? 2 : 4;
    w = 64 / n;
    ew = 20 / n;
    msk = w == 64 ? '1 : (64'd1 << w) - 1;
    emsk = (64'd1 << ew) - 1;
    minv = -(longint'(1) << (ew - 1));
    r = '0;
    r.pre = pre == 2'b11 ? 2'b00 : pre;
    for (int i = 0; i < n; i++) begin
      fb = (i + 1) * (4 / n) - 1;
      lm = (m >> (i * w)) & msk;
      ev = longint'((64'(e) >> (i * ew)) & emsk);
      if (ev >= -minv) ev = ev + 2 * minv;
      lz = 0;
      if (lm == 0) begin
        r.zero[fb] = 1'b1;
        res = minv;
      end else begin
        while (lm[w-1] == 1'b0) begin
          lm = lm << 1;
          lz++;
        end
        res = ev - lz;
        if (res < minv) begin
          r.uflow[fb] = 1'b1;
          res = minv;
        end
      end
      r.mant = r.mant | ((lm & msk) << (i * w));
      r.exp = r.exp | 20'((64'(res) & emsk) << (i * ew));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      acc_q.push_back(model(in_pre, in_mant, in_exp));
      acc_c.push_back(cyc);
    end
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_pre, out_mant, out_exp, out_zero, out_uflow});
      got_c.push_back(cyc);
    end
  end

  task automatic clear_q();
    acc_q.delete();
    got_q.delete();
    acc_c.delete();
    got_c.delete();
  endtask

  task automatic rand_in();
    in_pre = 2'($urandom_range(0, 3));
    in_mant = {$urandom, $urandom} >> $urandom_range(0, 63);
    for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) in_mant[i*16 +: 16] = '0;
    in_exp = $urandom_range(0, 1) ? 20'($urandom) : (20'($urandom) & 20'h00C63) | 20'h84210;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    out_ready = 1;
    while (got_q.size() < acc_q.size() && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL drain: timeout, got %0d beats want %0d", got_q.size(), acc_q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++;
    if ({out_pre, out_mant, out_exp, out_zero, out_uflow} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {out_pre, out_mant, out_exp, out_zero, out_uflow});
    end
    rst = 0;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    beat_t want[3];
    logic [1:0] pv[3];
    logic [63:0] mv[3];
    logic [19:0] ev[3];
    pv = '{2'b00, 2'b01, 2'b10};
    mv = '{64'h0000_0F00_8000_0001, 64'h1, 64'h1};
    ev = '{{5'd7, 5'd0, 5'd3, 5'd5}, {10'd0, 10'd100}, 20'h80012};
    want[0] = {2'b00, 64'h0000_F000_8000_8000, {5'b10000, 5'b11100, 5'd3, 5'b10110}, 4'b1000, 4'b0000};
    want[1] = {2'b01, 64'h0000_0000_8000_0000, {10'h200, 10'd69}, 4'b1000, 4'b0000};
    want[2] = {2'b10, 64'h8000_0000_0000_0000, 20'h80000, 4'b0000, 4'b1000};
    for (int k = 0; k < 3; k++) begin
      clear_q();
      @(posedge clk);
      #1;
      in_pre = pv[k];
      in_mant = mv[k];
      in_exp = ev[k];
      in_valid = 1;
      out_ready = 1;
      @(posedge clk);
      #1;
      drain();
      tests++;
      if (got_q.size() != 1 || acc_q.size() != 1) begin
        fails++;
        $display("FAIL directed%0d_count: got %0d beats want 1", k, got_q.size());
      end else begin
        tests++;
        if (got_q[0] !== want[k]) begin
          fails++;
          $display("FAIL directed%0d: got %h want %h", k, got_q[0], want[k]);
        end
        tests++;
        if (got_c[0] - acc_c[0] != 2) begin
          fails++;
          $display("FAIL directed%0d_latency: got %0d want 2", k, got_c[0] - acc_c[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rand_in();
      in_valid = 1;
      @(posedge clk);
      #1;
    end
    drain();
    tests++;
    if (acc_q.size() != 8 || got_q.size() != 8) begin
      fails++;
      $display("FAIL stream_count: got %0d accepted %0d out, want 8 8", acc_q.size(), got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      tests++;
      if (got_q[i] !== acc_q[i]) begin
        fails++;
        $display("FAIL stream_beat%0d: got %h want %h", i, got_q[i], acc_q[i]);
      end
      tests++;
      if (got_c[i] != acc_c[0] + 2 + i) begin
        fails++;
        $display("FAIL stream_timing%0d: got cycle %0d want %0d", i, got_c[i], acc_c[0] + 2 + i);
      end
    end
  endtask

  task automatic test_stall();
    beat_t snap;
    clear_q();
    @(posedge clk);
    #1;
    out_ready = 0;
    in_valid = 1;
    snap = '0;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      @(posedge clk);
      #1;
      if (i == 1) snap = {out_pre, out_mant, out_exp, out_zero, out_uflow};
    end
    tests++;
    if (acc_q.size() != 2) begin fails++; $display("FAIL stall_accepts: got %0d want 2", acc_q.size()); end
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_flags: got in_ready %b out_valid %b want 0 1", in_ready, out_valid);
    end
    tests++;
    if ({out_pre, out_mant, out_exp, out_zero, out_uflow} !== snap) begin
      fails++;
      $display("FAIL stall_stable: got %h want %h", {out_pre, out_mant, out_exp, out_zero, out_uflow}, snap);
    end
    if (acc_q.size() > 0) begin
      tests++;
      if (snap !== acc_q[0]) begin fails++; $display("FAIL stall_head: got %h want %h", snap, acc_q[0]); end
    end
    drain();
    tests++;
    if (got_q.size() != acc_q.size()) begin
      fails++;
      $display("FAIL stall_drain_count: got %0d want %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      tests++;
      if (got_q[i] !== acc_q[i]) begin
        fails++;
        $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], acc_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rand_in();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
    end
    drain();
    tests++;
    if (got_q.size() != acc_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d want %0d", got_q.size(), acc_q.size());
    end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      tests++;
      if (got_q[i] !== acc_q[i]) begin
        fails++;
        $display("FAIL random_beat%0d: got %h want %h", i, got_q[i], acc_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    @(posedge clk);
    #1;
    out_ready = 0;
    in_valid = 1;
    rand_in();
    @(posedge clk);
    #1;
    rand_in();
    @(posedge clk);
    #1;
    in_valid = 0;
    #2 rst = 1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    tests++;
    if ({out_pre, out_mant, out_exp, out_zero, out_uflow} !== '0) begin
      fails++;
      $display("FAIL midrst_data: got %h want 0", {out_pre, out_mant, out_exp, out_zero, out_uflow});
    end
    @(posedge clk);
    #1;
    rst = 0;
    clear_q();
    out_ready = 1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (got_q.size() != 0) begin fails++; $display("FAIL midrst_stale: got %0d beats want 0", got_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
